// File: rtl/alt_qkd_pkg.sv
// Shared definitions for the QKD post-processing chain: amplification defaults,
// e1 calculator state encoding and the start-to-valid latency helper.
package alt_qkd_pkg;

    localparam int WID_DEF    = 32;
    localparam int E1_AMP_DEF = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DIV   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } e1_state_t;

    // Cycles from the accepted start edge to the valid pulse on the division path.
    function automatic int lat_e1(input int wid, input int e1_amp);
        return wid + e1_amp + 1 + 3;
    endfunction

endpackage

// File: rtl/seq_udiv_rst.sv
// Generic restoring radix-2 unsigned divider, one quotient bit per cycle.
// done_o is high in the cycle whose closing edge completes the last iteration.
module seq_udiv_rst #(
    parameter int DVD_W = 57,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             done_o,
    output logic [DVD_W-1:0] quot_o
);

    localparam int CW = $clog2(DVD_W);

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DVD_W-1:0] dq_q, dq_d;
    logic [DVS_W-1:0] r_q, r_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [DVS_W:0]   r_sh_s;
    logic             ge_s;
    logic             last_s;

    // Shift/subtract step and iteration control.
    always_comb begin
        r_sh_s = {r_q, dq_q[DVD_W-1]};
        ge_s   = (r_sh_s >= {1'b0, dvs_q});
        last_s = busy_q && (cnt_q == CW'(DVD_W - 1));
        dq_d   = dq_q;
        r_d    = r_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            dq_d   = dividend_i;
            r_d    = {DVS_W{1'b0}};
            dvs_d  = divisor_i;
            cnt_d  = {CW{1'b0}};
            busy_d = 1'b1;
        end else if (busy_q) begin
            dq_d   = {dq_q[DVD_W-2:0], ge_s};
            // The remainder stays below the divisor, so DVS_W bits always hold it.
            r_d    = ge_s ? (r_sh_s[DVS_W-1:0] - dvs_q) : r_sh_s[DVS_W-1:0];
            cnt_d  = cnt_q + CW'(1);
            busy_d = ~last_s;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_q   <= {DVD_W{1'b0}};
            r_q    <= {DVS_W{1'b0}};
            dvs_q  <= {DVS_W{1'b0}};
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            r_q    <= r_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = last_s;
    assign quot_o = dq_q;

endmodule

// File: rtl/alt_cal_e1.sv
// Amplified error-rate calculator: o_e1 = round(err * 2^E1_AMP / bits), round half up,
// with invalid operands (bits == 0 or err > bits) flagged instead of divided.
module alt_cal_e1
    import alt_qkd_pkg::*;
#(
    parameter int WID    = WID_DEF,
    parameter int E1_AMP = E1_AMP_DEF,
    parameter int QBITS  = WID + E1_AMP + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [WID-1:0] i_err_cnt,
    input  logic [WID-1:0] i_bit_cnt,
    output logic           o_e1_busy,
    output logic [WID-1:0] o_e1,
    output logic           o_e1_vld,
    output logic           o_e1_error
);

    localparam logic [WID-1:0] E1_ONE = {{(WID-1){1'b0}}, 1'b1} << E1_AMP;

    e1_state_t        state_q, state_d;
    logic [WID-1:0]   e_q, e_d;
    logic [WID-1:0]   b_q, b_d;
    logic             bad_q, bad_d;
    logic [WID-1:0]   e1_q, e1_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             bad_in_s;
    logic             div_start_s;
    logic             div_done_s;
    logic [QBITS-1:0] dividend_s;
    logic [QBITS-1:0] quot_s;
    logic             hi_s;
    logic [WID-1:0]   rnd_s;
    logic [WID-1:0]   res_s;

    assign bad_in_s    = (b_q == {WID{1'b0}}) || (e_q > b_q);
    assign div_start_s = (state_q == CHECK) && !bad_in_s;
    assign dividend_s  = {e_q, {(E1_AMP + 1){1'b0}}};

    seq_udiv_rst #(
        .DVD_W (QBITS),
        .DVS_W (WID)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_s),
        .dividend_i (dividend_s),
        .divisor_i  (b_q),
        .done_o     (div_done_s),
        .quot_o     (quot_s)
    );

    // Quotient carries one extra fractional bit; hi_s cannot fire while err <= bits
    // but saturates rather than wraps should that invariant ever break.
    assign hi_s  = |quot_s[QBITS-1:WID+1];
    assign rnd_s = quot_s[WID:1] + {{(WID-1){1'b0}}, quot_s[0]};
    assign res_s = (bad_q || hi_s) ? E1_ONE : rnd_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the error path passes through ROUND so the result is formed in one place.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK:   state_d = bad_in_s ? ROUND : DIV;
            DIV:     state_d = div_done_s ? ROUND : DIV;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and operand next-value logic.
    always_comb begin
        e_d    = e_q;
        b_d    = b_q;
        bad_d  = bad_q;
        e1_d   = e1_q;
        vld_d  = 1'b0;
        err_d  = err_q;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    e_d   = i_err_cnt;
                    b_d   = i_bit_cnt;
                    bad_d = 1'b0;
                    err_d = 1'b0;
                end else begin
                    bad_d = bad_q;
                end
            end
            CHECK: bad_d = bad_in_s;
            ROUND: begin
                e1_d  = res_s;
                err_d = bad_q;
                vld_d = 1'b1;
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // Operand and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q    <= {WID{1'b0}};
            b_q    <= {WID{1'b0}};
            bad_q  <= 1'b0;
            e1_q   <= {WID{1'b0}};
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            e_q    <= e_d;
            b_q    <= b_d;
            bad_q  <= bad_d;
            e1_q   <= e1_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    assign o_e1_busy  = busy_q;
    assign o_e1       = e1_q;
    assign o_e1_vld   = vld_q;
    assign o_e1_error = err_q;

endmodule

// File: tb/tb_alt_cal_e1.sv
// Self-checking bench for alt_cal_e1: directed boundary cases plus randomized operands
// compared against an arithmetic rounding model.
module tb_alt_cal_e1;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_err_cnt;
    logic [31:0] i_bit_cnt;
    logic        o_e1_busy;
    logic [31:0] o_e1;
    logic        o_e1_vld;
    logic        o_e1_error;

    int          checks;
    int          failures;
    logic [31:0] prev_e1;

    alt_cal_e1 dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_err_cnt  (i_err_cnt),
        .i_bit_cnt  (i_bit_cnt),
        .o_e1_busy  (o_e1_busy),
        .o_e1       (o_e1),
        .o_e1_vld   (o_e1_vld),
        .o_e1_error (o_e1_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One operation starting from idle; inj > 0 fires a competing i_start in that cycle.
    task automatic run_op(input logic [31:0] e, input logic [31:0] b, input int inj, input string tag);
        longint unsigned num;
        longint unsigned den;
        logic [31:0]     exp_e1;
        logic            exp_err;
        int              exp_lat;
        int              lat;
        int              busy_bad;
        if (b == 32'd0 || e > b) begin
            exp_e1  = 32'h0100_0000;
            exp_err = 1'b1;
            exp_lat = 3;
        end else begin
            // round(e * 2^24 / b), half up == floor((2*e*2^24 + b) / (2*b))
            num     = ({32'd0, e} * 64'd33554432) + {32'd0, b};
            den     = {32'd0, b} * 64'd2;
            exp_e1  = 32'(num / den);
            exp_err = 1'b0;
            exp_lat = 60;
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, {63'd0, o_e1_busy}, 64'd0);
        chk({tag, "_idle_vld"}, {63'd0, o_e1_vld}, 64'd0);
        i_err_cnt = e;
        i_bit_cnt = b;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        i_err_cnt = $urandom;
        i_bit_cnt = $urandom;
        lat       = 1;
        busy_bad  = 0;
        chk({tag, "_err_clr"}, {63'd0, o_e1_error}, 64'd0);
        chk({tag, "_hold"}, {32'd0, o_e1}, {32'd0, prev_e1});
        while (o_e1_vld !== 1'b1 && lat < 200) begin
            if (o_e1_busy !== 1'b1) busy_bad++;
            if (lat == inj) begin
                i_start   = 1'b1;
                i_err_cnt = 32'd7;
                i_bit_cnt = 32'd9;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        i_start = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        chk({tag, "_busy_vld"}, {63'd0, o_e1_busy}, 64'd1);
        chk({tag, "_e1"}, {32'd0, o_e1}, {32'd0, exp_e1});
        chk({tag, "_error"}, {63'd0, o_e1_error}, {63'd0, exp_err});
        prev_e1 = exp_e1;
    endtask

    initial begin
        logic [31:0] re;
        logic [31:0] rb;
        int          vld_seen;
        int          busy_seen;
        checks    = 0;
        failures  = 0;
        prev_e1   = 32'd0;
        rst       = 1'b0;
        i_start   = 1'b0;
        i_err_cnt = 32'd0;
        i_bit_cnt = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_e1", {32'd0, o_e1}, 64'd0);
        chk("rst_vld", {63'd0, o_e1_vld}, 64'd0);
        chk("rst_busy", {63'd0, o_e1_busy}, 64'd0);
        chk("rst_error", {63'd0, o_e1_error}, 64'd0);
        rst = 1'b1;

        run_op(32'd1, 32'd4, 20, "quarter_ignore");
        run_op(32'd1, 32'd3, 0, "third");
        run_op(32'd2, 32'd3, 0, "two_thirds");
        run_op(32'd1, 32'h0200_0000, 0, "half_lsb");
        run_op(32'd123, 32'd0, 0, "zero_bits");
        run_op(32'd5, 32'd4, 0, "err_gt_bits");
        run_op(32'd0, 32'd1000, 0, "zero_err");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max_equal");

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        i_err_cnt = 32'd3;
        i_bit_cnt = 32'd7;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_e1", {32'd0, o_e1}, 64'd0);
        chk("arst_busy", {63'd0, o_e1_busy}, 64'd0);
        chk("arst_vld", {63'd0, o_e1_vld}, 64'd0);
        chk("arst_error", {63'd0, o_e1_error}, 64'd0);
        @(negedge clk);
        rst       = 1'b1;
        vld_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (o_e1_vld === 1'b1) vld_seen++;
            if (o_e1_busy === 1'b1) busy_seen++;
        end
        chk("arst_no_vld", 64'(vld_seen), 64'd0);
        chk("arst_no_busy", 64'(busy_seen), 64'd0);
        prev_e1 = 32'd0;
        run_op(32'd3, 32'd7, 0, "after_rst");

        // Randomized operands across valid, equal and invalid regions.
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(3))
                0: begin
                    rb = $urandom_range(1000) + 32'd1;
                    re = $urandom_range(int'(rb));
                end
                1: begin
                    rb = $urandom | 32'd1;
                    re = 32'(({32'd0, $urandom} * {32'd0, rb}) >> 32);
                end
                2: begin
                    rb = $urandom_range(65535);
                    re = rb + $urandom_range(1, 100);
                end
                default: begin
                    rb = $urandom;
                    re = rb;
                end
            endcase
            run_op(re, rb, 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
